quiz_responder_ctrl: RTL and testbench
======================================

Name: quiz_responder_ctrl

Overview:
Parametrised quiz-responder controller for N player buttons plus host start/clear. It replaces the fixed 4-player responder state machine. Added behaviour: an answer countdown window, a timeout, foul detection for early presses, and an optional per-player win counter. It sits between the key debouncer, which supplies one-cycle press pulses, and the 6-digit seven-segment scanner, which consumes a 24-bit BCD word.

Parameters:
N_PLAYERS, 4, number of player buttons; legal range 2..9.
TICK_DIV, 50_000_000, s_clk cycles per countdown second; legal minimum 2.
ARM_SEC, 30, answer-window length in seconds; legal range 1..99.
SCORE_EN, 1, 1 enables the per-player win counters; 0 ties scores to 0.

Ports:
s_clk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
key_flag  in  N_PLAYERS  debounced one-cycle press pulses, bit i = player i+1
host_start  in  1  one-cycle pulse: open the answer window
host_clear  in  1  one-cycle pulse: return to IDLE
Led  out  N_PLAYERS  one-hot winner/fouler indicator
winner_id  out  4  1-based player id; 0 = none
state_o  out  3  current state encoding
Number_Sig  out  24  BCD display word

Behaviour:
- Reset and clock: s_clk is the single clock. s_rst_n is asynchronous and active-low.
- Reset values: state IDLE, Led 0, winner_id 0, countdown ARM_SEC, tick counter 0, all scores 0. Number_Sig holds the IDLE pattern.
- States: IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3, FOUL=4. Other codes are unreachable and recover to IDLE.
- IDLE:
  - host_start -> ARMED. Countdown loads ARM_SEC and the tick counter clears.
  - Any key_flag bit -> FOUL. winner_id = lowest set index + 1; Led shows that bit.
  - If host_start and key_flag are both high in the same cycle, FOUL wins.
- ARMED:
  - Tick counter counts 0..TICK_DIV-1. On wrap, countdown decrements.
  - Any key_flag bit -> LOCKED. Lowest index wins on simultaneous presses. Led is one-hot for the winner. Score[winner] increments, saturating at 9.
  - Countdown reaching 0 with no press -> TIMEOUT. If a press and the expiry fall in the same cycle, the press wins.
  - host_start in ARMED is ignored.
- LOCKED, TIMEOUT, FOUL:
  - The countdown freezes.
  - All key_flag pulses are ignored; the first winner is never overwritten.
  - Only host_clear leaves these states.
- host_clear: from any state, next cycle -> IDLE. Led and winner_id clear, countdown reloads ARM_SEC. Scores are kept; only reset clears them. host_clear has priority over every other event in the same cycle.
- Latency: a press or host pulse at cycle k is visible on all outputs at cycle k+1. All outputs are registered.
- Countdown register: 7 bits, binary.
- BCD conversion: combinational divide-by-10 of the 0..99 values.
- Number_Sig layout:
  - [23:20] winner_id
  - [19:16] state code (0..4)
  - [15:12] countdown tens, [11:8] countdown units
  - [7:4] score tens (always 0), [3:0] score units of winner_id
  - When winner_id = 0, the score digits are 0.
- Parameter checks: N_PLAYERS is outside 2..9 or ARM_SEC outside 1..99 -> elaboration error via generate-time check.

Decomposition:
- Shared package: state encoding constants (ST_IDLE..ST_FOUL) and the BCD digit width.
- Sub-module bin2bcd_99: combinational 7-bit to two-digit BCD converter. It is instantiated for the countdown and reused by display logic elsewhere.
- Lowest-index priority encoder: a local function, not a module.

Test Plan:
- TICK_DIV=4, ARM_SEC=3. host_start, then no presses -> countdown 3,2,1,0 at 4-cycle spacing. TIMEOUT when countdown reaches 0; Number_Sig = 24'h030000.
- ARMED, then key_flag=4'b0110 in one cycle -> LOCKED, winner_id=2, Led=4'b0010. A later key_flag=4'b0001 is ignored. score[2]=1, Number_Sig[3:0]=1.
- IDLE, then key_flag=4'b1000 -> FOUL, winner_id=4, Led=4'b1000, state_o=4. host_clear -> IDLE, Led=0, countdown=3.
- Simultaneous cases:
  - host_start and key_flag=4'b0001 in IDLE -> FOUL, winner_id=1.
  - host_clear and key_flag=4'b0001 in ARMED -> IDLE, no score increment.
- Player 1 wins 11 rounds -> score saturates at 9. Drop s_rst_n mid-ARMED -> all outputs return to reset values without waiting for a clock edge; scores become 0.
- N_PLAYERS=9: key_flag bit 8 pressed in ARMED -> winner_id=9, Number_Sig[23:20]=4'h9.

Source files
------------

// File: rtl/quiz_responder_ctrl_pkg.sv
// Shared types for the quiz responder controller.
// Holds the state encoding and the BCD digit width.
package quiz_responder_ctrl_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_t;

endpackage

// File: rtl/quiz_responder_ctrl_if.sv
// Player/host inputs and display/indicator outputs of the responder.
// master drives the buttons (bench/debouncer), slave is the controller.
interface quiz_responder_ctrl_if #(
    parameter int N_PLAYERS = 4
) ();

    logic [N_PLAYERS-1:0] key_flag;
    logic                 host_start;
    logic                 host_clear;
    logic [N_PLAYERS-1:0] Led;
    logic [3:0]           winner_id;
    logic [2:0]           state_o;
    logic [23:0]          Number_Sig;

    modport master (
        output key_flag, host_start, host_clear,
        input  Led, winner_id, state_o, Number_Sig
    );

    modport slave (
        input  key_flag, host_start, host_clear,
        output Led, winner_id, state_o, Number_Sig
    );

endinterface

// File: rtl/quiz_responder_ctrl_bin2bcd_99.sv
// Combinational 7-bit binary (0..99) to two BCD digits.
// Ports: bin in, tens/units out.
module bin2bcd_99
    import quiz_responder_ctrl_pkg::*;
(
    input  logic [6:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    always_comb begin
        tens  = BCD_W'(bin / 7'd10);
        units = BCD_W'(bin % 7'd10);
    end

endmodule

// File: rtl/quiz_responder_ctrl.sv
// Quiz responder: answer window, lock-out, timeout, foul, win counters.
// Ports: s_clk, s_rst_n, bus (slave: keys/host in, Led/id/state/BCD out).
module quiz_responder_ctrl
    import quiz_responder_ctrl_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int TICK_DIV  = 50_000_000,
    parameter int ARM_SEC   = 30,
    parameter int SCORE_EN  = 1
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    quiz_responder_ctrl_if.slave  bus
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0]    ARM_V  = 7'(ARM_SEC);
    localparam logic [TW-1:0] TICK_L = TW'(TICK_DIV - 1);

    if (N_PLAYERS < 2 || N_PLAYERS > 9) begin : g_bad_players
        $error("quiz_responder_ctrl: N_PLAYERS must be 2..9");
    end
    if (ARM_SEC < 1 || ARM_SEC > 99) begin : g_bad_arm
        $error("quiz_responder_ctrl: ARM_SEC must be 1..99");
    end

    // Lowest set index wins; returns 1-based id, 0 if nothing pressed.
    function automatic logic [3:0] lowest_id(
        input logic [N_PLAYERS-1:0] k
    );
        lowest_id = 4'd0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (k[i]) lowest_id = 4'(i + 1);
        end
    endfunction

    state_t               state, state_n;
    logic [N_PLAYERS-1:0] led_q, led_n;
    logic [3:0]           win_q, win_n;
    logic [6:0]           cnt_q, cnt_n;
    logic [TW-1:0]        tick_q, tick_n;
    logic [3:0]           score_q [N_PLAYERS];
    logic [3:0]           win_score;
    logic [3:0]           press_id;
    logic [N_PLAYERS-1:0] press_oh;
    logic                 any_key;
    logic                 tick_wrap;
    logic                 expire;
    logic                 score_inc;
    logic [3:0]           cnt_t, cnt_u;

    always_comb begin
        any_key   = |bus.key_flag;
        press_id  = lowest_id(bus.key_flag);
        // Isolate the lowest set bit.
        press_oh  = bus.key_flag
                  & (~bus.key_flag + {{(N_PLAYERS-1){1'b0}}, 1'b1});
        tick_wrap = (tick_q == TICK_L);
        expire    = tick_wrap && (cnt_q <= 7'd1);
    end

    // State register.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        if (bus.host_clear) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_key)             state_n = ST_FOUL;
                    else if (bus.host_start) state_n = ST_ARMED;
                end
                ST_ARMED: begin
                    if (any_key)     state_n = ST_LOCKED;
                    else if (expire) state_n = ST_TIMEOUT;
                end
                ST_LOCKED, ST_TIMEOUT, ST_FOUL: state_n = state;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and counters.
    always_comb begin
        led_n     = led_q;
        win_n     = win_q;
        cnt_n     = cnt_q;
        tick_n    = tick_q;
        score_inc = 1'b0;
        if (bus.host_clear) begin
            led_n  = '0;
            win_n  = 4'd0;
            cnt_n  = ARM_V;
            tick_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_key) begin
                        led_n = press_oh;
                        win_n = press_id;
                    end else if (bus.host_start) begin
                        cnt_n  = ARM_V;
                        tick_n = '0;
                    end
                end
                ST_ARMED: begin
                    if (any_key) begin
                        led_n     = press_oh;
                        win_n     = press_id;
                        score_inc = 1'b1;
                    end else if (tick_wrap) begin
                        tick_n = '0;
                        cnt_n  = cnt_q - 7'd1;
                    end else begin
                        tick_n = tick_q + 1'b1;
                    end
                end
                ST_LOCKED, ST_TIMEOUT, ST_FOUL: ;
                default: begin
                    led_n  = '0;
                    win_n  = 4'd0;
                    cnt_n  = ARM_V;
                    tick_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            led_q  <= '0;
            win_q  <= 4'd0;
            cnt_q  <= ARM_V;
            tick_q <= '0;
        end else begin
            led_q  <= led_n;
            win_q  <= win_n;
            cnt_q  <= cnt_n;
            tick_q <= tick_n;
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_score
        if (SCORE_EN != 0) begin : g_on
            always_ff @(posedge s_clk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    score_q[i] <= 4'd0;
                end else if (score_inc
                             && press_id == 4'(i + 1)
                             && score_q[i] < 4'd9) begin
                    score_q[i] <= score_q[i] + 4'd1;
                end
            end
        end else begin : g_off
            assign score_q[i] = 4'd0;
        end
    end

    always_comb begin
        win_score = 4'd0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (win_q == 4'(i + 1)) win_score = score_q[i];
        end
    end

    bin2bcd_99 u_cnt_bcd (
        .bin   (cnt_q),
        .tens  (cnt_t),
        .units (cnt_u)
    );

    // Output drive.
    always_comb begin
        bus.Led        = led_q;
        bus.winner_id  = win_q;
        bus.state_o    = state;
        bus.Number_Sig = {win_q, 1'b0, state, cnt_t, cnt_u,
                          4'd0, win_score};
    end

endmodule

// File: tb/tb_quiz_responder_ctrl.sv
// Directed bench: 4-player and 9-player responders, TICK_DIV=4, ARM_SEC=3.
// Checks timeout, lock, foul, clear priority, saturation and async reset.
module tb_quiz_responder_ctrl;

    logic s_clk = 1'b0;
    logic s_rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 s_clk = ~s_clk;

    quiz_responder_ctrl_if #(.N_PLAYERS(4)) b4 ();
    quiz_responder_ctrl_if #(.N_PLAYERS(9)) b9 ();

    quiz_responder_ctrl #(
        .N_PLAYERS(4), .TICK_DIV(4), .ARM_SEC(3), .SCORE_EN(1)
    ) dut4 (
        .s_clk   (s_clk),
        .s_rst_n (s_rst_n),
        .bus     (b4.slave)
    );

    quiz_responder_ctrl #(
        .N_PLAYERS(9), .TICK_DIV(4), .ARM_SEC(3), .SCORE_EN(1)
    ) dut9 (
        .s_clk   (s_clk),
        .s_rst_n (s_rst_n),
        .bus     (b9.slave)
    );

    task automatic cyc();
        @(posedge s_clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start4();
        b4.host_start = 1'b1;
        cyc();
        b4.host_start = 1'b0;
    endtask

    task automatic clear4();
        b4.host_clear = 1'b1;
        cyc();
        b4.host_clear = 1'b0;
    endtask

    task automatic key4(input logic [3:0] k);
        b4.key_flag = k;
        cyc();
        b4.key_flag = 4'b0;
    endtask

    initial begin
        s_rst_n       = 1'b0;
        b4.key_flag   = '0;
        b4.host_start = 1'b0;
        b4.host_clear = 1'b0;
        b9.key_flag   = '0;
        b9.host_start = 1'b0;
        b9.host_clear = 1'b0;
        #22;
        chk("rst_state", 32'(b4.state_o), 32'd0);
        chk("rst_led", 32'(b4.Led), 32'd0);
        chk("rst_win", 32'(b4.winner_id), 32'd0);
        chk("rst_num", 32'(b4.Number_Sig), 32'h000300);
        chk("rst_num9", 32'(b9.Number_Sig), 32'h000300);
        s_rst_n = 1'b1;
        cyc();

        // Countdown to timeout.
        start4();
        chk("arm_num", 32'(b4.Number_Sig), 32'h010300);
        repeat (4) cyc();
        chk("cnt2", 32'(b4.Number_Sig), 32'h010200);
        repeat (4) cyc();
        chk("cnt1", 32'(b4.Number_Sig), 32'h010100);
        repeat (3) cyc();
        chk("cnt1_hold", 32'(b4.Number_Sig), 32'h010100);
        cyc();
        chk("timeout", 32'(b4.Number_Sig), 32'h030000);
        repeat (5) cyc();
        chk("timeout_frz", 32'(b4.Number_Sig), 32'h030000);
        clear4();
        chk("clr_to", 32'(b4.Number_Sig), 32'h000300);

        // Lock with simultaneous presses; later press ignored.
        start4();
        key4(4'b0110);
        chk("lock_win", 32'(b4.winner_id), 32'd2);
        chk("lock_led", 32'(b4.Led), 32'b0010);
        chk("lock_num", 32'(b4.Number_Sig), 32'h220301);
        key4(4'b0001);
        chk("lock_keep", 32'(b4.Number_Sig), 32'h220301);
        chk("lock_led2", 32'(b4.Led), 32'b0010);
        clear4();

        // Foul in IDLE.
        key4(4'b1000);
        chk("foul_st", 32'(b4.state_o), 32'd4);
        chk("foul_led", 32'(b4.Led), 32'b1000);
        chk("foul_num", 32'(b4.Number_Sig), 32'h440300);
        clear4();
        chk("foul_clr_led", 32'(b4.Led), 32'd0);
        chk("foul_clr_num", 32'(b4.Number_Sig), 32'h000300);

        // host_start with a press in IDLE: foul wins.
        b4.host_start = 1'b1;
        b4.key_flag   = 4'b0001;
        cyc();
        b4.host_start = 1'b0;
        b4.key_flag   = 4'b0;
        chk("sim_foul", 32'(b4.Number_Sig), 32'h140300);
        clear4();

        // host_clear with a press in ARMED: clear wins, no score.
        start4();
        cyc();
        b4.host_clear = 1'b1;
        b4.key_flag   = 4'b0001;
        cyc();
        b4.host_clear = 1'b0;
        b4.key_flag   = 4'b0;
        chk("sim_clr", 32'(b4.Number_Sig), 32'h000300);
        start4();
        key4(4'b0001);
        chk("p1_first", 32'(b4.Number_Sig), 32'h120301);

        // Ten more wins for player 1: saturates at 9.
        for (int r = 2; r <= 11; r++) begin
            clear4();
            start4();
            key4(4'b0001);
            if (r == 8) chk("p1_r8", 32'(b4.Number_Sig), 32'h120308);
        end
        chk("p1_sat", 32'(b4.Number_Sig), 32'h120309);
        clear4();

        // Asynchronous reset mid-ARMED.
        start4();
        repeat (2) cyc();
        chk("pre_rst", 32'(b4.state_o), 32'd1);
        #1;
        s_rst_n = 1'b0;
        #1;
        chk("arst_num", 32'(b4.Number_Sig), 32'h000300);
        chk("arst_led", 32'(b4.Led), 32'd0);
        chk("arst_win", 32'(b4.winner_id), 32'd0);
        #10;
        s_rst_n = 1'b1;
        cyc();
        start4();
        key4(4'b0001);
        chk("score_rst", 32'(b4.Number_Sig), 32'h120301);

        // Nine-player build: top player wins.
        b9.host_start = 1'b1;
        cyc();
        b9.host_start = 1'b0;
        b9.key_flag   = 9'h100;
        cyc();
        b9.key_flag   = '0;
        chk("p9_win", 32'(b9.winner_id), 32'd9);
        chk("p9_led", 32'(b9.Led), 32'h100);
        chk("p9_num", 32'(b9.Number_Sig), 32'h920301);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
